// File: rtl/reg_bridge_pkg.sv
// reg_bridge_pkg: shared constants, state encodings and sizing helpers for reg_bridge.
// Rev 1.0
`default_nettype none

package reg_bridge_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    PS_HUNT = 2'd0,
    PS_ADDR = 2'd1,
    PS_DATA = 2'd2,
    PS_CHK  = 2'd3
  } parse_state_t;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int calc_div(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000 + baud / 2) / baud;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 2-FF synchronised 8N1 receiver with glitch rejection and framing check.
// Rev 1.0
`default_nettype none

module uart_rx
  import reg_bridge_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW       = cnt_width(DIV);
  localparam logic [CW-1:0]  HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]  BIT_END  = CW'(DIV - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_last;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync && rx_last) state <= RX_START;
        end
        RX_START: begin
          // A start bit must still be low half a bit later, else it was a glitch.
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Strobes are decoded in the stop-sample cycle so the parser can register its result next cycle.
  assign stop_sample = (state == RX_STOP) && (cnt == BIT_END);
  assign byte_valid  = stop_sample && rx_sync;
  assign frame_err   = stop_sample && !rx_sync;
  assign byte_data   = shreg;
  assign busy        = (state != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/reg_bridge.sv
// reg_bridge: UART frame parser driving register writes (A5, addr, data[, checksum]).
// REG_BRIDGE_CHECKSUM_EN selects the 4-byte checksummed frame. Rev 1.0
`default_nettype none

module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int CLK_MHZ      = 100,
  parameter int BAUD         = 115200,
  parameter int ADDR_MAX     = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic [$clog2(ADDR_MAX+1)-1:0]   addr,
  output logic [7:0]                      data,
  output logic                            en,
  output logic                            err
);

  localparam int             DIV         = calc_div(CLK_MHZ, BAUD);
  localparam int             AW          = $clog2(ADDR_MAX + 1);
  localparam int             TIMEOUT_CYC = TIMEOUT_BITS * DIV;
  localparam int             TW          = cnt_width(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TO_END      = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     ADDR_MAX_B  = 8'(ADDR_MAX);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;
  logic          rx_busy;
  parse_state_t  pstate;
  logic [7:0]    addr_cap;
  logic [TW-1:0] tcnt;
  logic          frame_last;
  logic          frame_ok;
  logic [7:0]    wr_data;

  uart_rx #(
    .DIV (DIV)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (rx_busy)
  );

`ifdef REG_BRIDGE_CHECKSUM_EN
  logic [7:0] data_cap;
  logic [7:0] chk_sum;

  assign chk_sum    = SYNC_BYTE + addr_cap + data_cap;
  assign frame_last = (pstate == PS_CHK);
  assign frame_ok   = (addr_cap <= ADDR_MAX_B) && (rx_byte == chk_sum);
  assign wr_data    = data_cap;
`else
  assign frame_last = (pstate == PS_DATA);
  assign frame_ok   = (addr_cap <= ADDR_MAX_B);
  assign wr_data    = rx_byte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate   <= PS_HUNT;
      addr_cap <= '0;
      addr     <= '0;
      data     <= '0;
      en       <= 1'b0;
      err      <= 1'b0;
      tcnt     <= '0;
`ifdef REG_BRIDGE_CHECKSUM_EN
      data_cap <= '0;
`endif
    end else begin
      en  <= 1'b0;
      err <= 1'b0;
      // Inter-byte gap is only measured while the receiver is idle mid-frame.
      tcnt <= (pstate == PS_HUNT || rx_busy || byte_valid) ? '0 : tcnt + 1'b1;
      if (frame_err) begin
        err    <= 1'b1;
        pstate <= PS_HUNT;
      end else if (byte_valid && frame_last) begin
        if (frame_ok) begin
          en   <= 1'b1;
          addr <= addr_cap[AW-1:0];
          data <= wr_data;
        end else begin
          err <= 1'b1;
        end
        pstate <= PS_HUNT;
      end else if (byte_valid) begin
        case (pstate)
          PS_HUNT: if (rx_byte == SYNC_BYTE) pstate <= PS_ADDR;
          PS_ADDR: begin
            addr_cap <= rx_byte;
            pstate   <= PS_DATA;
          end
`ifdef REG_BRIDGE_CHECKSUM_EN
          PS_DATA: begin
            data_cap <= rx_byte;
            pstate   <= PS_CHK;
          end
`endif
          default: pstate <= PS_HUNT;
        endcase
      end else if (pstate != PS_HUNT && tcnt == TO_END) begin
        err    <= 1'b1;
        pstate <= PS_HUNT;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/reg_bridge.md
REG_BRIDGE -- requirements
Module: reg_bridge

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, system clock in MHz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter ADDR_MAX, default 4, highest legal register address.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 40, maximum idle gap between bytes of one frame, in bit times.
REQ-005 SHALL have ports: clk input 1, system clock; rst_n input 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rx input 1, asynchronous UART line, idle high.
REQ-007 SHALL have port addr output $clog2(ADDR_MAX+1), register address for the downstream generators.
REQ-008 SHALL have port data output 8, register write value.
REQ-009 SHALL have port en output 1, one-cycle write strobe qualifying addr/data.
REQ-010 SHALL have port err output 1, one-cycle pulse on any rejected byte or frame.

Function
REQ-011 SHALL pass rx through a 2-FF synchronizer before use; the synchronizer adds 2 cycles of latency.
REQ-012 SHALL use a bit period DIV = round(CLK_MHZ*1e6/BAUD) cycles (868 at the defaults), held in a counter sized from DIV.
REQ-013 SHALL implement the receiver FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-014 SHALL leave IDLE on a synchronized falling edge, then re-check rx at DIV/2 in START; high returns to IDLE with no err (glitch rejection).
REQ-015 SHALL sample 8 data bits LSB first at mid-bit, each DIV cycles after the previous sample.
REQ-016 SHALL accept the byte when the stop bit is high at mid-bit; stop low SHALL discard the byte, pulse err, and reset the parser.
REQ-017 SHALL run the parser FSM HUNT -> ADDR -> DATA -> CHK; HUNT waits for the byte 0xA5 and discards all other bytes silently.
REQ-018 SHALL capture a byte in ADDR and DATA, then in CHK compare the received byte with (0xA5 + addr + data) mod 256.
REQ-019 SHALL, on a valid frame with addr <= ADDR_MAX, drive addr and data and pulse en high for exactly one cycle, in the cycle after the CHK byte stop sample.
REQ-020 SHALL hold addr and data stable until the next en.
REQ-021 SHALL, on a checksum mismatch or addr > ADDR_MAX, not assert en, pulse err, and return the parser to HUNT.
REQ-022 SHALL, in a state other than HUNT, return the parser to HUNT with an err pulse when no new byte starts within TIMEOUT_BITS*DIV cycles.
REQ-023 SHALL give a framing error precedence over parser processing when both occur in the same byte.
REQ-024 SHALL never assert en and err in the same cycle.
REQ-025 SHALL allow back-to-back frames, with the next start bit arriving during or right after the CHK stop bit.

Reset
REQ-026 SHALL, while rst_n is low, clear addr, data, en, err and all counters, put the receiver in IDLE and the parser in HUNT, and preset the synchronizer to 1.
REQ-027 SHALL treat a reset asserted mid-frame as aborting the frame, with no en and no err.

Configuration
REQ-028 SHALL, when REG_BRIDGE_CHECKSUM_EN is defined, use the 4-byte frame with the CHK state.
REQ-029 SHALL, when REG_BRIDGE_CHECKSUM_EN is undefined, use 3-byte frames (0xA5, addr, data), omit the CHK state, and strobe en after the data byte; the address range check still applies.

Structure
REQ-030 SHALL place the SYNC byte value 0xA5, the rx/parser state enums and the divisor/width helper functions in the shared package reg_bridge_pkg.
REQ-031 SHALL contain one sub-module, uart_rx (synchronizer, receiver FSM, byte-valid and frame-error outputs), with the parser kept in reg_bridge.

Verification
REQ-032 SHALL check a valid frame: A5 02 4F F6 -> one en with addr=2, data=0x4F; err stays low.
REQ-033 SHALL check a bad checksum: A5 02 4F F7 -> no en, one err, and a following valid frame is accepted.
REQ-034 SHALL check an illegal address: A5 05 10 BA with ADDR_MAX=4 -> no en, one err.
REQ-035 SHALL check glitch and framing cases: a 100-cycle low pulse on rx gives no byte and no err; a byte with stop bit low gives err and the parser returns to HUNT.
REQ-036 SHALL check timeout: A5 01 then a gap of 41 bit times, then 20 33 -> err at the timeout and no en.
REQ-037 SHALL check reset and streaming: rst_n low during the data byte, then a valid frame -> exactly one en; two back-to-back frames -> two en with the correct values.
